code5_decoder: RTL and testbench

Streaming decoder for the 5-bit signed offset code produced by the team's 4-bit-to-5-bit code converter. It recovers the original 4-bit two's-complement value from each code word and flags words that are not legal codes. It sits on the receive side of the code link, between the incoming code stream and the consumer of 4-bit samples. It buffers up to two decoded words behind a valid/ready handshake and keeps a saturating error count.

---
 rtl/code5_decoder.sv | 130 +++++++++++++
 tb/tb_code5_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code5_decoder.sv
// code5_decoder: turns 5-bit offset-code words back into 4-bit two's-complement
// samples, flags illegal code words, and buffers up to two decoded words in a
// small skid FIFO behind valid/ready handshakes. It also keeps a saturating
// error count and a sticky error flag, both of which can be cleared.
module code5_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_x,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    input  logic             clr_err
);

    // Returns {x[3:0], err}. Legal code bands are 0, 4..10 (x = 1..7) and
    // 22..29 (x = -8..-1); every other code is illegal and decodes to zero.
    function automatic logic [4:0] decode5(input logic [4:0] c);
        logic [4:0] t;
        logic [4:0] r;
        t = 5'd0;
        r = {4'b0000, 1'b1};
        if (c == 5'd0) begin
            r = 5'd0;
        end else if (c >= 5'd4 && c <= 5'd10) begin
            t = c - 5'd3;
            r = {t[3:0], 1'b0};
        end else if (c >= 5'd22 && c <= 5'd29) begin
            t = c + 5'd2;
            r = {t[3:0], 1'b0};
        end
        return r;
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) r = v;
        else    r = v + CNT_W'(1);
        return r;
    endfunction

    logic [3:0]       mem_x_q   [0:1];
    logic             mem_err_q [0:1];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    logic             push;
    logic             pop;
    logic             illegal_push;
    logic [4:0]       dec;

    assign dec          = decode5(in_code);
    assign push         = in_valid & in_ready_q;
    assign pop          = (count_q != 2'd0) & out_ready;
    assign illegal_push = push & dec[0];

    // Next-state for FIFO pointers/occupancy, registered in_ready and error tracking.
    always_comb begin
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // in_ready is derived from the next occupancy so it never looks at out_ready.
        in_ready_d = (count_d != 2'd2);

        // A clear coinciding with a new illegal word leaves that error counted.
        if (clr_err) begin
            err_cnt_d    = illegal_push ? CNT_W'(1) : '0;
            err_sticky_d = illegal_push;
        end else if (illegal_push) begin
            err_cnt_d    = sat_inc(err_cnt_q);
            err_sticky_d = 1'b1;
        end
    end

    // Control state with asynchronous reset; reset drops all buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // FIFO storage; contents are only meaningful while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x_q[wr_ptr_q]   <= dec[4:1];
            mem_err_q[wr_ptr_q] <= dec[0];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (count_q != 2'd0);
    // Head data is masked while empty so stale storage never shows after reset.
    assign out_x      = out_valid ? mem_x_q[rd_ptr_q]   : 4'd0;
    assign out_err    = out_valid ? mem_err_q[rd_ptr_q] : 1'b0;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_code5_decoder.sv
// Testbench for code5_decoder: scoreboard of expected {x, err} pairs built from
// an encoder-direction reference, plus directed checks on handshake, counter
// saturation/clear and asynchronous reset. A second instance with a 2-bit
// counter shares all inputs and is used for saturation checks.
module tb_code5_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_code;
    logic       out_ready;
    logic       clr_err;

    logic       in_ready, out_valid, out_err, err_sticky;
    logic [3:0] out_x;
    logic [7:0] err_cnt;

    logic       in_ready2, out_valid2, out_err2, err_sticky2;
    logic [3:0] out_x2;
    logic [1:0] err_cnt2;

    int n_vec;
    int n_miscmp;
    logic [4:0] sbq[$];

    code5_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_err(out_err), .err_cnt(err_cnt),
        .err_sticky(err_sticky), .clr_err(clr_err)
    );

    code5_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
        .out_x(out_x2), .out_err(out_err2), .err_cnt(err_cnt2),
        .err_sticky(err_sticky2), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference built from the encoder direction: find x whose code equals c.
    function automatic logic [4:0] ref_decode(input logic [4:0] c);
        logic [4:0] r;
        logic [4:0] code;
        logic [3:0] xv;
        r = 5'b0000_1;
        for (int x = -8; x <= 7; x++) begin
            if (x == 0)     code = 5'd0;
            else if (x > 0) code = 5'(x + 3);
            else            code = 5'(x - 2);
            xv = 4'(x);
            if (code == c) r = {xv, 1'b0};
        end
        return r;
    endfunction

    // Called at a falling edge with this cycle's inputs already applied:
    // records the transfers the next rising edge will perform, then waits.
    task automatic tick();
        logic [4:0] e;
        if (!out_valid && sbq.size() != 0)
            chk("missing_valid", 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("out_x", 32'(out_x), 32'(e[4:1]));
                chk("out_err", 32'(out_err), 32'(e[0]));
            end
        end
        if (in_valid && in_ready)
            sbq.push_back(ref_decode(in_code));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sbq.delete();
        rst_n = 1'b1;
    endtask

    logic [4:0] legal_codes [0:15];
    logic [4:0] bad_codes   [0:5];

    initial begin
        n_vec = 0;
        n_miscmp = 0;
        in_valid = 1'b0;
        in_code = 5'd0;
        out_ready = 1'b0;
        clr_err = 1'b0;
        rst_n = 1'b0;
        legal_codes = '{5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29,
                        5'd0, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
        bad_codes   = '{5'd1, 5'd3, 5'd11, 5'd21, 5'd30, 5'd31};

        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Legal sweep, x = -8..7 in order.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_code = legal_codes[i];
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("sweep_drained", sbq.size(), 32'd0);
        chk("sweep_err_cnt", 32'(err_cnt), 32'd0);
        chk("sweep_sticky", 32'(err_sticky), 32'd0);

        // Illegal codes.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_code = bad_codes[i];
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("illegal_drained", sbq.size(), 32'd0);
        chk("illegal_err_cnt", 32'(err_cnt), 32'd6);
        chk("illegal_sticky", 32'(err_sticky), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);

        // Backpressure: only two of three words accepted.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 5'd4;
        tick();
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        in_code = 5'd5;
        tick();
        in_code = 5'd6;
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("bp_ready_low2", 32'(in_ready), 32'd0);
        chk("bp_head_stable", 32'(out_x), 32'd1);
        chk("bp_occupancy", sbq.size(), 32'd2);
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("bp_drained", sbq.size(), 32'd0);

        // Simultaneous push and pop with one entry.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 5'd10;
        tick();
        in_code = 5'd22;
        out_ready = 1'b1;
        chk("pp_head_seven", 32'(out_x), 32'd7);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_out_x", 32'(out_x), 32'h8);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        chk("pp_occupancy", sbq.size(), 32'd1);
        tick();
        out_ready = 1'b1;
        tick(); tick();
        chk("pp_drained", sbq.size(), 32'd0);

        // Counter saturation (2-bit instance) and clear-with-error.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code = bad_codes[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("sat_cnt2", 32'(err_cnt2), 32'd3);
        chk("sat_sticky2", 32'(err_sticky2), 32'd1);
        chk("sat_cnt8", 32'(err_cnt), 32'd5);
        in_valid = 1'b1;
        in_code = 5'd31;
        clr_err = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_err = 1'b0;
        chk("clrerr_cnt2", 32'(err_cnt2), 32'd1);
        chk("clrerr_sticky2", 32'(err_sticky2), 32'd1);
        chk("clrerr_cnt8", 32'(err_cnt), 32'd1);
        tick(); tick();

        // Asynchronous reset with a full FIFO.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 5'd1;
        tick();
        in_code = 5'd4;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_sticky", 32'(err_sticky), 32'd0);
        chk("arst_out_x", 32'(out_x), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
